// File: rtl/alu_share_arb_if.sv
// Bundle of two requester handshakes and one response channel around the
// shared mini-ALU.
interface alu_share_arb_if;
    logic       req0_valid;
    logic       req0_ready;
    logic [2:0] req0_op;
    logic [4:0] req0_a;
    logic [4:0] req0_b;
    logic       req1_valid;
    logic       req1_ready;
    logic [2:0] req1_op;
    logic [4:0] req1_a;
    logic [4:0] req1_b;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_id;
    logic [4:0] rsp_data;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_data,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_data,
        input  rsp_ready
    );
endinterface

// File: rtl/alu_share_arb.sv
// Round-robin sharing controller for the 5-bit mini-ALU: accepts one request,
// evaluates it, and returns the registered result tagged with the requester id.
module alu_share_arb #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_share_arb_if.slave   bus,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic             busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             id_q, id_d;
    logic [2:0]       op_q, op_d;
    logic [4:0]       a_q, a_d;
    logic [4:0]       b_q, b_d;
    logic [4:0]       rsp_data_q, rsp_data_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    logic             grant;
    logic             accept;
    logic [4:0]       alu_y;

    // On a tie the requester that did not win last time gets the slot.
    always_comb begin
        grant = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant = ~last_grant_q;
        end else if (bus.req1_valid) begin
            grant = 1'b1;
        end
    end

    always_comb begin
        bus.req0_ready = (state_q == IDLE) && bus.req0_valid && !grant;
        bus.req1_ready = (state_q == IDLE) && bus.req1_valid && grant;
        accept         = bus.req0_ready || bus.req1_ready;
    end

    // Bit 4 always mirrors b[0]; this is how the existing ALU behaves.
    always_comb begin
        alu_y = '0;
        case (op_q)
            3'd0: alu_y = a_q + b_q;
            3'd1: alu_y = a_q - b_q;
            3'd2: alu_y = 5'd0 - a_q;
            3'd3: alu_y = 5'd0 - b_q;
            3'd4: alu_y = a_q & b_q;
            3'd5: alu_y = a_q | b_q;
            3'd6: alu_y = a_q ^ b_q;
            3'd7: alu_y = {b_q[3:0], 1'b0};
        endcase
        alu_y[4] = b_q[0];
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        rsp_data_d   = rsp_data_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    id_d    = grant;
                    op_d    = grant ? bus.req1_op : bus.req0_op;
                    a_d     = grant ? bus.req1_a  : bus.req0_a;
                    b_d     = grant ? bus.req1_b  : bus.req0_b;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d = alu_y;
                state_d    = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    last_grant_d = id_q;
                    if (id_q) begin
                        cnt1_d = cnt1_q + CNT_W'(1);
                    end else begin
                        cnt0_d = cnt0_q + CNT_W'(1);
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            rsp_data_q   <= '0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            rsp_data_q   <= rsp_data_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

    always_comb begin
        bus.rsp_valid = (state_q == RESP);
        bus.rsp_id    = id_q;
        bus.rsp_data  = rsp_data_q;
        busy          = (state_q != IDLE);
        cnt0          = cnt0_q;
        cnt1          = cnt1_q;
    end

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: arbitration, ALU results, backpressure,
// mid-operation reset and counter wrap (second instance with CNT_W=2).
module tb_alu_share_arb;

    logic       clk;
    logic       rst_n;
    logic [7:0] cnt0, cnt1;
    logic       busy;
    logic [1:0] cnt0_s, cnt1_s;
    logic       busy_s;
    int         checks;
    int         fails;

    alu_share_arb_if ifc();
    alu_share_arb_if ifc2();

    alu_share_arb u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifc),
        .cnt0 (cnt0),
        .cnt1 (cnt1),
        .busy (busy)
    );

    alu_share_arb #(.CNT_W(2)) u_dut_small (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifc2),
        .cnt0 (cnt0_s),
        .cnt1 (cnt1_s),
        .busy (busy_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        ifc.req0_valid = 0; ifc.req0_op = 0; ifc.req0_a = 0; ifc.req0_b = 0;
        ifc.req1_valid = 0; ifc.req1_op = 0; ifc.req1_a = 0; ifc.req1_b = 0;
        ifc.rsp_ready = 0;
        ifc2.req0_valid = 0; ifc2.req0_op = 0; ifc2.req0_a = 0; ifc2.req0_b = 0;
        ifc2.req1_valid = 0; ifc2.req1_op = 0; ifc2.req1_a = 0; ifc2.req1_b = 0;
        ifc2.rsp_ready = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset;
        #3;
        checks++;
        if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (ifc.rsp_valid !== 1'b0 || ifc.rsp_id !== 1'b0 || ifc.rsp_data !== 5'h00) begin
            fails++;
            $display("[TB] FAIL reset_rsp: got valid=%b id=%b data=%h expected 0/0/00", ifc.rsp_valid, ifc.rsp_id, ifc.rsp_data);
        end
        checks++;
        if (cnt0 !== 8'd0 || cnt1 !== 8'd0) begin fails++; $display("[TB] FAIL reset_cnt: got %0d/%0d expected 0/0", cnt0, cnt1); end
        checks++;
        if (ifc.req0_ready !== 1'b0 || ifc.req1_ready !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_ready: got %b%b expected 00", ifc.req0_ready, ifc.req1_ready);
        end
        next_cycle();
    endtask

    task automatic test_single;
        ifc.req0_valid = 1; ifc.req0_op = 3'd0; ifc.req0_a = 5'd9; ifc.req0_b = 5'd5;
        #3;
        checks++;
        if (ifc.req0_ready !== 1'b1 || ifc.req1_ready !== 1'b0) begin
            fails++;
            $display("[TB] FAIL single_ready: got %b%b expected 10", ifc.req0_ready, ifc.req1_ready);
        end
        next_cycle();
        ifc.req0_valid = 0;
        #3;
        checks++;
        if (ifc.rsp_valid !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("[TB] FAIL single_exec: got rsp_valid=%b busy=%b expected 0/1", ifc.rsp_valid, busy);
        end
        next_cycle();
        checks++;
        if (ifc.rsp_valid !== 1'b1 || ifc.rsp_id !== 1'b0 || ifc.rsp_data !== 5'h1E) begin
            fails++;
            $display("[TB] FAIL single_rsp: got valid=%b id=%b data=%h expected 1/0/1e", ifc.rsp_valid, ifc.rsp_id, ifc.rsp_data);
        end
        ifc.rsp_ready = 1;
        next_cycle();
        ifc.rsp_ready = 0;
        #3;
        checks++;
        if (ifc.rsp_valid !== 1'b0 || busy !== 1'b0 || cnt0 !== 8'd1) begin
            fails++;
            $display("[TB] FAIL single_done: got valid=%b busy=%b cnt0=%0d expected 0/0/1", ifc.rsp_valid, busy, cnt0);
        end
        next_cycle();
    endtask

    task automatic test_alu_ops;
        logic [2:0] ops [8];
        logic [4:0] av  [8];
        logic [4:0] bv  [8];
        logic [4:0] ev  [8];
        ops = '{3'd7, 3'd2, 3'd1, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0};
        av  = '{5'h00, 5'h01, 5'h03, 5'h00, 5'h0C, 5'h03, 5'h0F, 5'h1F};
        bv  = '{5'h13, 5'h00, 5'h05, 5'h06, 5'h0A, 5'h09, 5'h05, 5'h02};
        ev  = '{5'h16, 5'h0F, 5'h1E, 5'h0A, 5'h08, 5'h1B, 5'h1A, 5'h01};
        for (int i = 0; i < 8; i++) begin
            ifc.req1_valid = 1; ifc.req1_op = ops[i]; ifc.req1_a = av[i]; ifc.req1_b = bv[i];
            #3;
            checks++;
            if (ifc.req1_ready !== 1'b1 || ifc.req0_ready !== 1'b0) begin
                fails++;
                $display("[TB] FAIL alu_ready[%0d]: got %b%b expected 01", i, ifc.req0_ready, ifc.req1_ready);
            end
            next_cycle();
            ifc.req1_valid = 0;
            next_cycle();
            checks++;
            if (ifc.rsp_valid !== 1'b1 || ifc.rsp_id !== 1'b1 || ifc.rsp_data !== ev[i]) begin
                fails++;
                $display("[TB] FAIL alu_op%0d: got valid=%b id=%b data=%h expected 1/1/%h", ops[i], ifc.rsp_valid, ifc.rsp_id, ifc.rsp_data, ev[i]);
            end
            ifc.rsp_ready = 1;
            next_cycle();
            ifc.rsp_ready = 0;
        end
        #3;
        checks++;
        if (cnt1 !== 8'd8 || cnt0 !== 8'd1) begin fails++; $display("[TB] FAIL alu_cnt: got %0d/%0d expected 1/8", cnt0, cnt1); end
        next_cycle();
    endtask

    task automatic test_back_to_back;
        bit exp_r0, exp_r1, exp_v, exp_id;
        do_reset();
        ifc.req0_valid = 1; ifc.req0_op = 3'd0; ifc.req0_a = 5'h01; ifc.req0_b = 5'h02;
        ifc.req1_valid = 1; ifc.req1_op = 3'd6; ifc.req1_a = 5'h1F; ifc.req1_b = 5'h01;
        ifc.rsp_ready = 1;
        for (int k = 0; k < 18; k++) begin
            #3;
            exp_id = ((k / 3) % 2) == 1;
            exp_r0 = (k % 3 == 0) && !exp_id;
            exp_r1 = (k % 3 == 0) && exp_id;
            exp_v  = (k % 3 == 2);
            checks++;
            if (ifc.req0_ready !== exp_r0 || ifc.req1_ready !== exp_r1) begin
                fails++;
                $display("[TB] FAIL b2b_grant[%0d]: got %b%b expected %b%b", k, ifc.req0_ready, ifc.req1_ready, exp_r0, exp_r1);
            end
            checks++;
            if (ifc.rsp_valid !== exp_v) begin
                fails++;
                $display("[TB] FAIL b2b_valid[%0d]: got %b expected %b", k, ifc.rsp_valid, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (ifc.rsp_id !== exp_id || ifc.rsp_data !== (exp_id ? 5'h1E : 5'h03)) begin
                    fails++;
                    $display("[TB] FAIL b2b_rsp[%0d]: got id=%b data=%h expected %b/%h", k, ifc.rsp_id, ifc.rsp_data, exp_id, exp_id ? 5'h1E : 5'h03);
                end
            end
            next_cycle();
        end
        ifc.req0_valid = 0; ifc.req1_valid = 0; ifc.rsp_ready = 0;
        #3;
        checks++;
        if (cnt0 !== 8'd3 || cnt1 !== 8'd3) begin fails++; $display("[TB] FAIL b2b_cnt: got %0d/%0d expected 3/3", cnt0, cnt1); end
        next_cycle();
    endtask

    task automatic test_backpressure;
        ifc.req0_valid = 1; ifc.req0_op = 3'd4; ifc.req0_a = 5'h0F; ifc.req0_b = 5'h03;
        ifc.req1_valid = 1; ifc.req1_op = 3'd0; ifc.req1_a = 5'h00; ifc.req1_b = 5'h00;
        #3;
        checks++;
        if (ifc.req0_ready !== 1'b1 || ifc.req1_ready !== 1'b0) begin
            fails++;
            $display("[TB] FAIL bp_tie: got %b%b expected 10", ifc.req0_ready, ifc.req1_ready);
        end
        next_cycle();
        ifc.req0_valid = 0;
        next_cycle();
        for (int k = 0; k < 10; k++) begin
            #3;
            checks++;
            if (ifc.rsp_valid !== 1'b1 || ifc.rsp_data !== 5'h13 || ifc.rsp_id !== 1'b0 ||
                ifc.req0_ready !== 1'b0 || ifc.req1_ready !== 1'b0) begin
                fails++;
                $display("[TB] FAIL bp_hold[%0d]: got valid=%b data=%h id=%b rdy=%b%b expected 1/13/0/00",
                         k, ifc.rsp_valid, ifc.rsp_data, ifc.rsp_id, ifc.req0_ready, ifc.req1_ready);
            end
            next_cycle();
        end
        ifc.rsp_ready = 1;
        next_cycle();
        ifc.rsp_ready = 0;
        #3;
        checks++;
        if (ifc.rsp_valid !== 1'b0 || busy !== 1'b0 || ifc.req1_ready !== 1'b1 || cnt0 !== 8'd4) begin
            fails++;
            $display("[TB] FAIL bp_release: got valid=%b busy=%b r1=%b cnt0=%0d expected 0/0/1/4",
                     ifc.rsp_valid, busy, ifc.req1_ready, cnt0);
        end
        ifc.req1_valid = 0;
        next_cycle();
    endtask

    task automatic test_reset_mid;
        ifc.req0_valid = 1; ifc.req0_op = 3'd0; ifc.req0_a = 5'h01; ifc.req0_b = 5'h01;
        next_cycle();
        ifc.req0_valid = 0;
        #1;
        checks++;
        if (busy !== 1'b1) begin fails++; $display("[TB] FAIL rmid_exec: got busy=%b expected 1", busy); end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || ifc.rsp_valid !== 1'b0 || ifc.rsp_data !== 5'h00 || ifc.rsp_id !== 1'b0) begin
            fails++;
            $display("[TB] FAIL rmid_async: got busy=%b valid=%b data=%h id=%b expected 0/0/00/0",
                     busy, ifc.rsp_valid, ifc.rsp_data, ifc.rsp_id);
        end
        checks++;
        if (cnt0 !== 8'd0 || cnt1 !== 8'd0) begin fails++; $display("[TB] FAIL rmid_cnt: got %0d/%0d expected 0/0", cnt0, cnt1); end
        next_cycle();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #3;
            checks++;
            if (ifc.rsp_valid !== 1'b0 || cnt0 !== 8'd0) begin
                fails++;
                $display("[TB] FAIL rmid_quiet[%0d]: got valid=%b cnt0=%0d expected 0/0", k, ifc.rsp_valid, cnt0);
            end
            next_cycle();
        end
        ifc.req0_valid = 1; ifc.req1_valid = 1;
        #3;
        checks++;
        if (ifc.req0_ready !== 1'b1 || ifc.req1_ready !== 1'b0) begin
            fails++;
            $display("[TB] FAIL rmid_tie: got %b%b expected 10", ifc.req0_ready, ifc.req1_ready);
        end
        ifc.req0_valid = 0; ifc.req1_valid = 0;
        next_cycle();
    endtask

    task automatic test_cnt_wrap;
        logic [1:0] seq [5];
        logic [4:0] bval;
        logic [4:0] exp_d;
        seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        for (int i = 0; i < 5; i++) begin
            bval  = 5'(i + 1);
            exp_d = {bval[0], bval[3:0]};
            ifc2.req0_valid = 1; ifc2.req0_op = 3'd5; ifc2.req0_a = 5'h00; ifc2.req0_b = bval;
            #3;
            checks++;
            if (ifc2.req0_ready !== 1'b1) begin fails++; $display("[TB] FAIL wrap_ready[%0d]: got %b expected 1", i, ifc2.req0_ready); end
            next_cycle();
            ifc2.req0_valid = 0;
            next_cycle();
            checks++;
            if (ifc2.rsp_valid !== 1'b1 || ifc2.rsp_data !== exp_d) begin
                fails++;
                $display("[TB] FAIL wrap_rsp[%0d]: got valid=%b data=%h expected 1/%h", i, ifc2.rsp_valid, ifc2.rsp_data, exp_d);
            end
            ifc2.rsp_ready = 1;
            next_cycle();
            ifc2.rsp_ready = 0;
            #3;
            checks++;
            if (cnt0_s !== seq[i] || cnt1_s !== 2'd0 || busy_s !== 1'b0) begin
                fails++;
                $display("[TB] FAIL wrap_cnt[%0d]: got cnt0=%0d cnt1=%0d busy=%b expected %0d/0/0", i, cnt0_s, cnt1_s, busy_s, seq[i]);
            end
            next_cycle();
        end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        do_reset();
        test_reset();
        test_single();
        test_alu_ops();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_cnt_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Two-port sharing controller for the team's 5-bit mini-ALU (3-bit op select, 8 ops). Two independent requesters present operand/op transactions over valid/ready handshakes. The block arbitrates round-robin, drives the single shared ALU, registers the result, and returns it over a response handshake tagged with the requester id. It sits between the two issuing engines and the ALU instance, which is embedded combinationally inside this block.

## Interface
- CNT_W, 8, width of the per-requester completed-op counters

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has a transaction
- req0_ready  out  1  requester 0 transaction accepted this cycle
- req0_op  in  3  requester 0 ALU op code
- req0_a  in  5  requester 0 operand A
- req0_b  in  5  requester 0 operand B
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as above, for requester 1
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_id  out  1  requester that issued the result (0/1)
- rsp_data  out  5  ALU result
- cnt0  out  CNT_W  completed responses for requester 0, wraps modulo 2^CNT_W
- cnt1  out  CNT_W  same, for requester 1
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states are IDLE, EXEC and RESP.
- IDLE: grant goes to the single valid requester. If both are valid, grant goes to the requester opposite last_grant.
  - Granted reqN_ready is driven combinationally high in the same cycle; the other ready stays low.
  - On handshake (valid&ready), latch op, a, b and id, then go to EXEC.
  - If neither requester is valid, stay in IDLE.
- EXEC: the ALU evaluates the latched operands; capture its result into the rsp_data register; go to RESP.
- RESP: rsp_valid=1, with rsp_data and rsp_id held stable until rsp_ready.
  - On rsp_valid&rsp_ready: update last_grant to id, increment cnt[id] (wrapping), go to IDLE.
- Both ready outputs are 0 in EXEC and RESP. Requester inputs are ignored there; requesters must hold valid and data until ready.
- ALU semantics, 5-bit modulo, with a=latched A and b=latched B:
  - 0: a+b
  - 1: a-b
  - 2: -a (two's complement)
  - 3: -b
  - 4: a&b
  - 5: a|b
  - 6: a^b
  - 7: b<<1
- The shared ALU forces result[4]=b[0] for every op. This is the existing datapath behaviour and is preserved. The scoreboard models it, and the block does not correct it.
- Carries and borrows are discarded. No flags are produced.

## Timing
- Reset values: state=IDLE, last_grant=1 (req0 wins the first tie), rsp_valid=0, rsp_id=0, rsp_data=0, cnt0=cnt1=0, busy=0.
  - Both ready outputs evaluate to 0 unless a valid request is present.
- Latency: handshake in cycle T, then rsp_valid=1 from cycle T+2.
- Minimum issue interval is 3 cycles (accept, EXEC, RESP with rsp_ready tied high). The next accept is possible in cycle T+3.
- Backpressure: with rsp_ready low, RESP is held indefinitely. No new request is accepted and outputs are stable.
- Simultaneous valid on both requesters resolves strictly alternately under sustained contention.
- A request that drops valid before being granted is not latched and leaves no trace.
- Reset asserted mid-operation (EXEC or RESP) clears everything immediately. The in-flight transaction is discarded, produces no response and is not counted.
- Counter wrap: at 2^CNT_W-1, the next completion gives 0.

## Test plan
- Single req0 op=0, a=9, b=5 -> req0_ready high in accept cycle; rsp_valid at T+2 with rsp_id=0, rsp_data=0x0E (bit4=b[0]=1 forces 0x1E); cnt0=1.
- Both valid continuously from reset, rsp_ready=1, 6 ops -> grants in order 0,1,0,1,0,1; a new accept every 3 cycles; cnt0=cnt1=3.
- req1 op=7, b=0x13, then op=2, a=1, b=0 -> rsp_data=0x16 then 0x0F (0x1F with bit4 forced to b[0]=0).
- rsp_ready held low 10 cycles in RESP -> rsp_valid, rsp_data, rsp_id stable; both ready=0; then one rsp_ready pulse -> IDLE next cycle.
- rst_n pulsed low during EXEC -> outputs at reset values asynchronously; no response emitted; counters 0; next tie grants req0.
- CNT_W=2, 5 req0 completions -> cnt0 sequence 1,2,3,0,1.
